// File: rtl/comparator_sort_controller_if.sv
// comparator_sort_controller_if: start/busy/done handshake and data bus of the
// bubble-sort controller. The requester drives Start_In and Data_In through the
// master modport. The sorter drives the result and status through the slave modport.
interface comparator_sort_controller_if #(
  parameter int NUM_ELEMENTS = 4
);
  logic                      Start_In;
  logic [4*NUM_ELEMENTS-1:0] Data_In;
  logic [4*NUM_ELEMENTS-1:0] Data_Out;
  logic                      Busy_Out;
  logic                      Done_Out;
  logic [4:0]                Swap_Count_Out;

  modport master (
    output Start_In,
    output Data_In,
    input  Data_Out,
    input  Busy_Out,
    input  Done_Out,
    input  Swap_Count_Out
  );

  modport slave (
    input  Start_In,
    input  Data_In,
    output Data_Out,
    output Busy_Out,
    output Done_Out,
    output Swap_Count_Out
  );
endinterface

// File: rtl/comparator_sort_controller.sv
// comparator_sort_controller: ascending bubble sort of NUM_ELEMENTS 4-bit values.
// The sort shares one Comparator_4_Bit and evaluates one adjacent pair per cycle.
// Optional build macro SORT_EARLY_EXIT_EN: when defined, the sort ends after the
// first pass that performs no swap. When undefined, every pass always runs.
// Comparator_4_Bit: 4-bit magnitude comparator. A high Reset_In forces all flags low.
module Comparator_4_Bit (
  input  logic       Reset_In,
  input  logic [3:0] A_In,
  input  logic [3:0] B_In,
  output logic       A_Greater_Than_B_Out,
  output logic       A_Equal_B_Out,
  output logic       A_Less_Than_B_Out
);
  // Magnitude compare of A against B, suppressed while in reset
  always_comb begin
    A_Greater_Than_B_Out = 1'b0;
    A_Equal_B_Out        = 1'b0;
    A_Less_Than_B_Out    = 1'b0;
    if (Reset_In) begin
      A_Greater_Than_B_Out = 1'b0;
    end else begin
      A_Greater_Than_B_Out = (A_In > B_In);
      A_Equal_B_Out        = (A_In == B_In);
      A_Less_Than_B_Out    = (A_In < B_In);
    end
  end
endmodule

module comparator_sort_controller #(
  parameter int NUM_ELEMENTS = 4
) (
  input  logic                          Clock_In,
  input  logic                          Reset_In,
  comparator_sort_controller_if.slave   sort_bus
);
  localparam int IDX_W = 3;
  localparam logic [IDX_W-1:0] LAST_PASS = IDX_W'(NUM_ELEMENTS - 2);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_COMPARE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t                    state_r, state_s;
  logic [3:0]                work_r [NUM_ELEMENTS];
  logic [3:0]                work_s [NUM_ELEMENTS];
  logic [IDX_W-1:0]          p_r, p_s, j_r, j_s, last_j_s;
  logic [4:0]                cnt_r, cnt_s, swap_out_r, swap_out_s;
  logic [4*NUM_ELEMENTS-1:0] data_out_r, data_out_s;
  logic                      busy_r, busy_s, done_r, done_s;
  logic [3:0]                a_s, b_s;
  logic                      gt_s, eq_s, lt_s, swap_s, finish_s;
`ifdef SORT_EARLY_EXIT_EN
  logic                      swapped_r, swapped_s;
`endif

  // Operand select: element j feeds A, element j+1 feeds B
  always_comb begin
    a_s = 4'd0;
    b_s = 4'd0;
    for (int k = 0; k < NUM_ELEMENTS - 1; k++) begin
      if (j_r == k[IDX_W-1:0]) begin
        a_s = work_r[k];
        b_s = work_r[k+1];
      end else begin
        a_s = a_s;
      end
    end
  end

  Comparator_4_Bit u_cmp (
    .Reset_In             (1'b0),
    .A_In                 (a_s),
    .B_In                 (b_s),
    .A_Greater_Than_B_Out (gt_s),
    .A_Equal_B_Out        (eq_s),
    .A_Less_Than_B_Out    (lt_s)
  );

  // Swap only on a clean greater-than; equal pairs stay put so the sort is stable
  assign swap_s   = gt_s & ~eq_s & ~lt_s;
  assign last_j_s = LAST_PASS - p_r;

  // Next-state, working array, counters and output values
  always_comb begin
    state_s    = state_r;
    work_s     = work_r;
    p_s        = p_r;
    j_s        = j_r;
    cnt_s      = cnt_r;
    data_out_s = data_out_r;
    busy_s     = busy_r;
    done_s     = 1'b0;
    swap_out_s = swap_out_r;
    finish_s   = 1'b0;
`ifdef SORT_EARLY_EXIT_EN
    swapped_s  = swapped_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (sort_bus.Start_In) begin
          state_s = ST_LOAD;
          busy_s  = 1'b1;
          for (int k = 0; k < NUM_ELEMENTS; k++) begin
            work_s[k] = sort_bus.Data_In[4*k +: 4];
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        state_s = ST_COMPARE;
        p_s     = {IDX_W{1'b0}};
        j_s     = {IDX_W{1'b0}};
        cnt_s   = 5'd0;
`ifdef SORT_EARLY_EXIT_EN
        swapped_s = 1'b0;
`endif
      end
      ST_COMPARE: begin
        if (swap_s) begin
          cnt_s = cnt_r + 5'd1;
          for (int k = 0; k < NUM_ELEMENTS - 1; k++) begin
            if (j_r == k[IDX_W-1:0]) begin
              work_s[k]   = work_r[k+1];
              work_s[k+1] = work_r[k];
            end else begin
              work_s[k] = work_s[k];
            end
          end
        end else begin
          cnt_s = cnt_r;
        end
`ifdef SORT_EARLY_EXIT_EN
        finish_s = (p_r == LAST_PASS) || !(swapped_r || swap_s);
`else
        finish_s = (p_r == LAST_PASS);
`endif
        if (j_r == last_j_s) begin
          if (finish_s) begin
            state_s    = ST_DONE;
            busy_s     = 1'b0;
            done_s     = 1'b1;
            swap_out_s = cnt_s;
            for (int k = 0; k < NUM_ELEMENTS; k++) begin
              data_out_s[4*k +: 4] = work_s[k];
            end
          end else begin
            p_s = p_r + 3'd1;
            j_s = {IDX_W{1'b0}};
`ifdef SORT_EARLY_EXIT_EN
            swapped_s = 1'b0;
`endif
          end
        end else begin
          j_s = j_r + 3'd1;
`ifdef SORT_EARLY_EXIT_EN
          swapped_s = swapped_r | swap_s;
`endif
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge Clock_In) begin
    if (Reset_In) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath and output registers
  always_ff @(posedge Clock_In) begin
    if (Reset_In) begin
      for (int k = 0; k < NUM_ELEMENTS; k++) begin
        work_r[k] <= 4'd0;
      end
      p_r        <= {IDX_W{1'b0}};
      j_r        <= {IDX_W{1'b0}};
      cnt_r      <= 5'd0;
      data_out_r <= {(4*NUM_ELEMENTS){1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      swap_out_r <= 5'd0;
`ifdef SORT_EARLY_EXIT_EN
      swapped_r  <= 1'b0;
`endif
    end else begin
      work_r     <= work_s;
      p_r        <= p_s;
      j_r        <= j_s;
      cnt_r      <= cnt_s;
      data_out_r <= data_out_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      swap_out_r <= swap_out_s;
`ifdef SORT_EARLY_EXIT_EN
      swapped_r  <= swapped_s;
`endif
    end
  end

  assign sort_bus.Data_Out       = data_out_r;
  assign sort_bus.Busy_Out       = busy_r;
  assign sort_bus.Done_Out       = done_r;
  assign sort_bus.Swap_Count_Out = swap_out_r;
endmodule

// File: tb/tb_comparator_sort_controller.sv
// tb_comparator_sort_controller: directed vectors for the 4-element sorter with
// hand-computed results, swap counts and start-to-done latencies.
module tb_comparator_sort_controller;
  localparam int N = 4;
`ifdef SORT_EARLY_EXIT_EN
  localparam int LAT_SORTED = 4;
  localparam int LAT_DUP    = 6;
`else
  localparam int LAT_SORTED = 7;
  localparam int LAT_DUP    = 7;
`endif

  logic Clock_In = 1'b0;
  logic Reset_In;
  int   checks   = 0;
  int   failures = 0;

  comparator_sort_controller_if #(.NUM_ELEMENTS(N)) sort_bus ();

  comparator_sort_controller #(.NUM_ELEMENTS(N)) dut (
    .Clock_In (Clock_In),
    .Reset_In (Reset_In),
    .sort_bus (sort_bus)
  );

  always #5 Clock_In = ~Clock_In;

  task automatic check_value(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_value({tag, "_data"}, 32'(sort_bus.Data_Out), 32'h0);
    check_value({tag, "_busy"}, 32'(sort_bus.Busy_Out), 32'h0);
    check_value({tag, "_done"}, 32'(sort_bus.Done_Out), 32'h0);
    check_value({tag, "_swaps"}, 32'(sort_bus.Swap_Count_Out), 32'h0);
  endtask

  // One sort: Start_In pulsed for edge E0, latency counted in edges after E0.
  // interfere pulses Start_In with other data mid-sort; reset_at > 0 asserts
  // Reset_In so that it is sampled at edge E(reset_at+1), then the task returns.
  task automatic run_sort(input string tag, input logic [15:0] din,
                          input logic [15:0] exp_data, input logic [4:0] exp_swaps,
                          input int exp_lat, input bit interfere, input int reset_at);
    int cyc;
    bit seen;
    @(negedge Clock_In);
    sort_bus.Start_In = 1'b1;
    sort_bus.Data_In  = din;
    @(posedge Clock_In);
    #1;
    sort_bus.Start_In = 1'b0;
    sort_bus.Data_In  = ~din;
    check_value({tag, "_busy_on"}, 32'(sort_bus.Busy_Out), 32'h1);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 100) begin
      if (interfere && cyc == 2) begin
        sort_bus.Start_In = 1'b1;
        sort_bus.Data_In  = 16'hFA50;
      end else begin
        sort_bus.Start_In = 1'b0;
      end
      if (reset_at > 0 && cyc == reset_at) begin
        Reset_In = 1'b1;
      end
      @(posedge Clock_In);
      #1;
      cyc++;
      if (reset_at > 0 && cyc == reset_at + 1) begin
        check_all_zero({tag, "_rst"});
        Reset_In = 1'b0;
        return;
      end
      seen = sort_bus.Done_Out;
    end
    sort_bus.Start_In = 1'b0;
    check_value({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    check_value({tag, "_data"}, 32'(sort_bus.Data_Out), 32'(exp_data));
    check_value({tag, "_swaps"}, 32'(sort_bus.Swap_Count_Out), 32'(exp_swaps));
    check_value({tag, "_busy_off"}, 32'(sort_bus.Busy_Out), 32'h0);
    @(posedge Clock_In);
    #1;
    check_value({tag, "_done_pulse"}, 32'(sort_bus.Done_Out), 32'h0);
    check_value({tag, "_data_hold"}, 32'(sort_bus.Data_Out), 32'(exp_data));
  endtask

  initial begin
    Reset_In          = 1'b1;
    sort_bus.Start_In = 1'b0;
    sort_bus.Data_In  = 16'h0000;
    repeat (2) @(posedge Clock_In);
    #1;
    check_all_zero("reset");
    Reset_In = 1'b0;
    repeat (3) @(posedge Clock_In);
    #1;
    check_value("idle_busy", 32'(sort_bus.Busy_Out), 32'h0);

    run_sort("reverse", 16'h0123, 16'h3210, 5'd6, 7, 1'b0, 0);
    run_sort("sorted",  16'hFA50, 16'hFA50, 5'd0, LAT_SORTED, 1'b0, 0);
    run_sort("dup",     16'h7373, 16'h7733, 5'd1, LAT_DUP, 1'b0, 0);
    run_sort("mixed",   16'h1A2B, 16'hBA21, 5'd5, 7, 1'b0, 0);
    run_sort("ignore",  16'h0123, 16'h3210, 5'd6, 7, 1'b1, 0);
    run_sort("midrst",  16'h0123, 16'h3210, 5'd6, 7, 1'b0, 3);
    run_sort("fresh",   16'h7373, 16'h7733, 5'd1, LAT_DUP, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
